// File: rtl/tick_gen_pkg.sv
// Shared constants for the fan-controller tick generator.
// Standard periods assume a 1 kHz clk with PRESCALE = 1.
package tick_gen_pkg;

  localparam int P_1S    = 1000;
  localparam int P_500MS = 500;
  localparam int P_250MS = 250;
  localparam int P_200MS = 200;
  localparam int P_100MS = 100;

  localparam int CH_1S    = 0;
  localparam int CH_500MS = 1;
  localparam int CH_250MS = 2;
  localparam int CH_200MS = 3;
  localparam int CH_100MS = 4;

  // A prescaler of 1 still needs a one-bit counter so the compare stays legal.
  function automatic int pre_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Control and pulse bundle between a timing master and tick_gen.
interface tick_gen_if
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 10
);

  logic                    en;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       oneshot;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*CNT_W-1:0] period_i;
  logic                    base_tick_o;
  logic [NUM_CH-1:0]       tick_o;
  logic [NUM_CH-1:0]       done_o;

  modport master (
    output en, ch_en, oneshot, load, period_i,
    input  base_tick_o, tick_o, done_o
  );

  modport slave (
    input  en, ch_en, oneshot, load, period_i,
    output base_tick_o, tick_o, done_o
  );

endinterface

// File: rtl/tick_gen_ch.sv
// One tick channel: holds its own period and mode, counts prescaler strobes
// and emits a one-cycle pulse on terminal count. A one-shot channel halts
// with done set until it is reloaded or disabled.
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stb,
  input  logic             ch_en,
  input  logic             oneshot,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  output logic             tick,
  output logic             done
);

  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] cnt;
  logic             mode_r;

  // Prioritised channel update: load, disable, idle, terminal count, count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_r <= '0;
      cnt      <= '0;
      mode_r   <= 1'b0;
      tick     <= 1'b0;
      done     <= 1'b0;
    end else if (load) begin
      period_r <= period;
      mode_r   <= oneshot;
      cnt      <= '0;
      done     <= 1'b0;
      tick     <= 1'b0;
    end else if (!ch_en) begin
      cnt  <= '0;
      tick <= 1'b0;
      done <= 1'b0;
    end else if (period_r == '0 || done) begin
      tick <= 1'b0;
    end else if (stb && cnt == period_r - CNT_W'(1)) begin
      // period_r is nonzero here, so the decrement cannot wrap.
      cnt  <= '0;
      tick <= 1'b1;
      if (mode_r) done <= 1'b1;
    end else if (stb) begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator: a shared prescaler produces the base strobe,
// and each channel divides that strobe by its own run-time period.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH   = 5,
  parameter int CNT_W    = 10,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  tick_gen_if.slave   bus
);

  localparam int PRE_W = pre_width(PRESCALE);

  logic [PRE_W-1:0]  pre_cnt;
  logic              stb;
  logic              base_tick_r;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] done_w;

  // All channels see the same strobe, so their phases stay aligned.
  assign stb = bus.en && (pre_cnt == PRE_W'(PRESCALE - 1));

  // Prescaler advances only while running and wraps on the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      base_tick_r <= 1'b0;
    end else begin
      base_tick_r <= stb;
      if (bus.en) pre_cnt <= stb ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_gen_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .stb     (stb),
      .ch_en   (bus.ch_en[g]),
      .oneshot (bus.oneshot[g]),
      .load    (bus.load[g]),
      .period  (bus.period_i[g*CNT_W +: CNT_W]),
      .tick    (tick_w[g]),
      .done    (done_w[g])
    );
  end

  assign bus.base_tick_o = base_tick_r;
  assign bus.tick_o      = tick_w;
  assign bus.done_o      = done_w;

endmodule

// File: tb/tb_tick_gen.sv
module tb_tick_gen;
  import tick_gen_pkg::*;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 10;
  localparam int PER [NUM_CH] = '{P_1S, P_500MS, P_250MS, P_200MS, P_100MS};

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  tick_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) if1 ();
  tick_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) if4 ();

  tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    if1.en = 1'b0; if1.ch_en = '0; if1.oneshot = '0; if1.load = '0; if1.period_i = '0;
    if4.en = 1'b0; if4.ch_en = '0; if4.oneshot = '0; if4.load = '0; if4.period_i = '0;
    repeat (3) @(negedge clk);
    n_total++; if (if1.tick_o !== 5'b0) $display("FAIL reset_tick1 got %b exp 00000", if1.tick_o); else n_pass++;
    n_total++; if (if1.done_o !== 5'b0) $display("FAIL reset_done1 got %b exp 00000", if1.done_o); else n_pass++;
    n_total++; if (if1.base_tick_o !== 1'b0) $display("FAIL reset_base1 got %b exp 0", if1.base_tick_o); else n_pass++;
    n_total++; if (if4.tick_o !== 5'b0) $display("FAIL reset_tick4 got %b exp 00000", if4.tick_o); else n_pass++;
    n_total++; if (if4.done_o !== 5'b0) $display("FAIL reset_done4 got %b exp 00000", if4.done_o); else n_pass++;
    n_total++; if (if4.base_tick_o !== 1'b0) $display("FAIL reset_base4 got %b exp 0", if4.base_tick_o); else n_pass++;
  endtask

  task automatic test_periodic();
    int err [NUM_CH];
    int cnt [NUM_CH];
    int berr;
    logic exp_t;
    berr = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      err[i] = 0; cnt[i] = 0;
      if1.period_i[i*CNT_W +: CNT_W] = CNT_W'(PER[i]);
    end
    rst_n = 1'b1;
    if1.ch_en = '1; if1.oneshot = '0; if1.load = '1; if1.en = 1'b0;
    @(negedge clk);
    if1.load = '0; if1.en = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
        exp_t = (k % PER[i] == 0);
        if (if1.tick_o[i] !== exp_t) err[i]++;
        if (if1.tick_o[i] === 1'b1) cnt[i]++;
      end
      if (if1.base_tick_o !== 1'b1) berr++;
      if (k == 1000 || k == 2000) begin
        n_total++;
        if (if1.tick_o !== 5'h1f) $display("FAIL periodic_coincide cycle %0d got %b exp 11111", k, if1.tick_o);
        else n_pass++;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      n_total++;
      if (err[i] !== 0) $display("FAIL periodic_phase ch%0d got %0d bad cycles exp 0", i, err[i]); else n_pass++;
      n_total++;
      if (cnt[i] !== 2000 / PER[i]) $display("FAIL periodic_count ch%0d got %0d exp %0d", i, cnt[i], 2000 / PER[i]);
      else n_pass++;
    end
    n_total++;
    if (berr !== 0) $display("FAIL periodic_base got %0d bad cycles exp 0", berr); else n_pass++;
  endtask

  task automatic test_prescale();
    int berr, terr, nb, nt;
    berr = 0; terr = 0; nb = 0; nt = 0;
    if4.ch_en = 5'b00001; if4.oneshot = '0;
    if4.period_i = '0; if4.period_i[0 +: CNT_W] = CNT_W'(3);
    if4.load = 5'b00001; if4.en = 1'b0;
    @(negedge clk);
    if4.load = '0; if4.en = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      if (if4.base_tick_o !== (k % 4 == 0)) berr++;
      if (if4.tick_o !== {4'b0, (k % 12 == 0)}) terr++;
      if (if4.base_tick_o === 1'b1) nb++;
      if (if4.tick_o[0] === 1'b1) nt++;
    end
    if4.en = 1'b0;
    n_total++; if (berr !== 0) $display("FAIL prescale_base_phase got %0d bad cycles exp 0", berr); else n_pass++;
    n_total++; if (terr !== 0) $display("FAIL prescale_tick_phase got %0d bad cycles exp 0", terr); else n_pass++;
    n_total++; if (nb !== 12) $display("FAIL prescale_base_count got %0d exp 12", nb); else n_pass++;
    n_total++; if (nt !== 4) $display("FAIL prescale_tick_count got %0d exp 4", nt); else n_pass++;
  endtask

  task automatic test_oneshot();
    int terr, derr;
    for (int pass = 0; pass < 2; pass++) begin
      terr = 0; derr = 0;
      if1.en = 1'b0; if1.ch_en = 5'b00001; if1.oneshot = 5'b00001;
      if1.period_i[0 +: CNT_W] = CNT_W'(5);
      if1.load = 5'b00001;
      @(negedge clk);
      if (pass == 1) begin
        n_total++;
        if (if1.done_o !== 5'b0) $display("FAIL oneshot_reload_clears_done got %b exp 00000", if1.done_o); else n_pass++;
      end
      if1.load = '0; if1.en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (if1.tick_o !== {4'b0, (k == 5)}) terr++;
        if (if1.done_o !== {4'b0, (k >= 5)}) derr++;
      end
      n_total++; if (terr !== 0) $display("FAIL oneshot_tick pass%0d got %0d bad cycles exp 0", pass, terr); else n_pass++;
      n_total++; if (derr !== 0) $display("FAIL oneshot_done pass%0d got %0d bad cycles exp 0", pass, derr); else n_pass++;
    end
  endtask

  task automatic test_pause();
    int err, nt;
    err = 0; nt = 0;
    if1.en = 1'b0; if1.ch_en = 5'b00001; if1.oneshot = '0;
    if1.period_i[0 +: CNT_W] = CNT_W'(100);
    if1.load = 5'b00001;
    @(negedge clk);
    if1.load = '0;
    for (int c = 1; c <= 250; c++) begin
      if1.en = !(c >= 51 && c <= 87);
      @(negedge clk);
      if (if1.tick_o[0] !== (c == 137 || c == 237)) err++;
      if (if1.tick_o[0] === 1'b1) nt++;
    end
    n_total++; if (err !== 0) $display("FAIL pause_phase got %0d bad cycles exp 0", err); else n_pass++;
    n_total++; if (nt !== 2) $display("FAIL pause_count got %0d exp 2", nt); else n_pass++;
  endtask

  task automatic test_load_tc();
    int err0, err1, n0, n1;
    err0 = 0; err1 = 0; n0 = 0; n1 = 0;
    if1.en = 1'b0; if1.ch_en = 5'b00011; if1.oneshot = '0;
    if1.period_i[0 +: CNT_W] = CNT_W'(4);
    if1.period_i[CNT_W +: CNT_W] = CNT_W'(3);
    if1.load = 5'b00011;
    @(negedge clk);
    if1.load = '0;
    if1.period_i[CNT_W +: CNT_W] = '0;
    for (int c = 1; c <= 2000; c++) begin
      if1.en = 1'b1;
      if1.load = {3'b0, (c == 6), (c == 4)};
      @(negedge clk);
      if (if1.tick_o[0] !== (c >= 8 && c % 4 == 0)) err0++;
      if (if1.tick_o[1] !== (c == 3)) err1++;
      if (if1.tick_o[0] === 1'b1) n0++;
      if (if1.tick_o[1] === 1'b1) n1++;
    end
    if1.load = '0;
    n_total++; if (err0 !== 0) $display("FAIL load_tc_phase got %0d bad cycles exp 0", err0); else n_pass++;
    n_total++; if (err1 !== 0) $display("FAIL period0_phase got %0d bad cycles exp 0", err1); else n_pass++;
    n_total++; if (n0 !== 499) $display("FAIL load_tc_count got %0d exp 499", n0); else n_pass++;
    n_total++; if (n1 !== 1) $display("FAIL period0_count got %0d exp 1", n1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int err, nb;
    err = 0; nb = 0;
    if1.en = 1'b0; if1.ch_en = 5'b00011; if1.oneshot = 5'b00010;
    if1.period_i[0 +: CNT_W] = CNT_W'(2);
    if1.period_i[CNT_W +: CNT_W] = CNT_W'(1);
    if1.load = 5'b00011;
    @(negedge clk);
    if1.load = '0; if1.en = 1'b1;
    repeat (6) @(negedge clk);
    n_total++;
    if (if1.done_o !== 5'b00010) $display("FAIL reset_mid_pre_done got %b exp 00010", if1.done_o); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_total++; if (if1.tick_o !== 5'b0) $display("FAIL reset_mid_tick got %b exp 00000", if1.tick_o); else n_pass++;
    n_total++; if (if1.done_o !== 5'b0) $display("FAIL reset_mid_done got %b exp 00000", if1.done_o); else n_pass++;
    n_total++; if (if1.base_tick_o !== 1'b0) $display("FAIL reset_mid_base got %b exp 0", if1.base_tick_o); else n_pass++;
    rst_n = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (if1.tick_o !== 5'b0 || if1.done_o !== 5'b0) err++;
      if (if1.base_tick_o === 1'b1) nb++;
    end
    n_total++; if (err !== 0) $display("FAIL reset_mid_silent got %0d bad cycles exp 0", err); else n_pass++;
    n_total++; if (nb !== 50) $display("FAIL reset_mid_base_count got %0d exp 50", nb); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_prescale();
    test_oneshot();
    test_pause();
    test_load_tc();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
